digit_serial_sub: RTL and testbench

//  Parametrised, multi-cycle subtractor: {bo, d} = a - b - bi on WIDTH-bit operands,

---
 rtl/digit_serial_sub_pkg.sv | 18 +
 rtl/digit_sub.sv | 22 ++
 rtl/digit_serial_sub.sv | 154 +++++++++++++++
 tb/tb_digit_serial_sub.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/digit_serial_sub_pkg.sv
// Shared types and defaults for the digit-serial subtractor.
// Holds the FSM encoding and the signed-overflow helper.
package digit_serial_sub_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DIGIT = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Overflow when the operand signs differ and the result sign departs from the minuend.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/digit_sub.sv
// Combinational DIGIT-bit subtractor slice: {bout, diff} = x - y - bin.
module digit_sub #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    output logic [DIGIT-1:0] diff,
    output logic             bout
);

    logic [DIGIT:0] full_s;

    // Widened subtraction; the extra top bit is the borrow out of this digit.
    always_comb begin
        full_s = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bin};
    end

    assign diff = full_s[DIGIT-1:0];
    assign bout = full_s[DIGIT];

endmodule

// File: rtl/digit_serial_sub.sv
// Multi-cycle subtractor: one DIGIT-wide slice per clock with a registered borrow,
// start/busy/done handshake, unsigned borrow-out and signed overflow flag.
module digit_serial_sub
    import digit_serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [WIDTH-1:0] a_r, a_s;
    logic [WIDTH-1:0] b_r, b_s;
    logic             brw_r, brw_s;
    logic [WIDTH-1:0] res_r, res_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic [WIDTH-1:0] d_r, d_s;
    logic             bo_r, bo_s;
    logic             ovf_r, ovf_s;

    logic [IW-1:0]    idx_s;
    logic [DIGIT-1:0] x_s;
    logic [DIGIT-1:0] y_s;
    logic [DIGIT-1:0] dig_s;
    logic             bout_s;
    logic [WIDTH-1:0] res_upd_s;

    // Bit offset of the digit being processed this cycle.
    always_comb begin
        idx_s = IW'(cnt_r * DIGIT);
        x_s   = a_r[idx_s +: DIGIT];
        y_s   = b_r[idx_s +: DIGIT];
    end

    digit_sub #(
        .DIGIT (DIGIT)
    ) u_digit_sub (
        .x    (x_s),
        .y    (y_s),
        .bin  (brw_r),
        .diff (dig_s),
        .bout (bout_s)
    );

    // Partial result with the current digit merged in.
    always_comb begin
        res_upd_s                   = res_r;
        res_upd_s[idx_s +: DIGIT]   = dig_s;
    end

    // Next-state and next-output logic; d/bo/ovf only change on the final digit.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        a_s     = a_r;
        b_s     = b_r;
        brw_s   = brw_r;
        res_s   = res_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        d_s     = d_r;
        bo_s    = bo_r;
        ovf_s   = ovf_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    a_s     = a;
                    b_s     = b;
                    brw_s   = bi;
                    cnt_s   = {CW{1'b0}};
                    busy_s  = 1'b1;
                    state_s = ST_RUN;
                end else begin
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                res_s = res_upd_s;
                brw_s = bout_s;
                if (cnt_r == CW'(N - 1)) begin
                    d_s     = res_upd_s;
                    bo_s    = bout_s;
                    ovf_s   = sub_ovf(a_r[WIDTH-1], b_r[WIDTH-1], res_upd_s[WIDTH-1]);
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    cnt_s   = {CW{1'b0}};
                    state_s = ST_IDLE;
                end else begin
                    cnt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    state_s = ST_RUN;
                end
            end
            default: begin
                busy_s  = 1'b0;
                cnt_s   = {CW{1'b0}};
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            brw_r   <= 1'b0;
            res_r   <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            d_r     <= {WIDTH{1'b0}};
            bo_r    <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            a_r     <= a_s;
            b_r     <= b_s;
            brw_r   <= brw_s;
            res_r   <= res_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            d_r     <= d_s;
            bo_r    <= bo_s;
            ovf_r   <= ovf_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign d    = d_r;
    assign bo   = bo_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_digit_serial_sub.sv
// Directed bench for digit_serial_sub: a 16/4 instance and a degenerate 4/4 instance.
module tb_digit_serial_sub;

    logic        clk;
    logic        rst;
    logic        start16, bi16, busy16, done16, bo16, ovf16;
    logic [15:0] a16, b16, d16;
    logic        start4, bi4, busy4, done4, bo4, ovf4;
    logic [3:0]  a4, b4, d4;

    int checks;
    int failures;
    int lat;
    int busy_cyc;
    int hold_bad;
    int dones;

    digit_serial_sub #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bi(bi16),
        .busy(busy16), .done(done16), .d(d16), .bo(bo16), .ovf(ovf16)
    );

    digit_serial_sub #(.WIDTH(4), .DIGIT(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bi(bi4),
        .busy(busy4), .done(done4), .d(d4), .bo(bo4), .ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Issue one op on the 16-bit unit at the current negedge and wait for done.
    task automatic run16(input logic [15:0] aa, input logic [15:0] bb, input logic bii,
                         input logic [15:0] hold_d, output int l, output int bc, output int hb);
        a16 = aa; b16 = bb; bi16 = bii; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        l = 0; bc = 0; hb = 0;
        while (!done16 && l < 20) begin
            if (busy16) bc++;
            if (d16 !== hold_d) hb++;
            tick();
            l++;
        end
        chk("timeout16", {31'd0, done16}, 32'd1);
        chk("busy_at_done", {31'd0, busy16}, 32'd0);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        start16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; bi16 = 1'b0;
        start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; bi4 = 1'b0;
        tick(); tick();
        rst = 1'b0;

        chk("rst_busy", {31'd0, busy16}, 32'd0);
        chk("rst_done", {31'd0, done16}, 32'd0);
        chk("rst_d", {16'd0, d16}, 32'h0);
        chk("rst_bo", {31'd0, bo16}, 32'd0);
        chk("rst_ovf", {31'd0, ovf16}, 32'd0);

        // 1: 0 - 1 wraps
        run16(16'h0000, 16'h0001, 1'b0, 16'h0000, lat, busy_cyc, hold_bad);
        chk("t1_lat", 32'(lat), 32'd4);
        chk("t1_d", {16'd0, d16}, 32'h0000FFFF);
        chk("t1_bo", {31'd0, bo16}, 32'd1);
        chk("t1_ovf", {31'd0, ovf16}, 32'd0);
        chk("t1_hold_run", 32'(hold_bad), 32'd0);
        tick();
        chk("t1_done_pulse", {31'd0, done16}, 32'd0);
        tick(); tick();
        chk("t1_d_held", {16'd0, d16}, 32'h0000FFFF);

        // 2: borrow-in consumed, busy exactly 4 cycles
        run16(16'h1234, 16'h0234, 1'b1, 16'hFFFF, lat, busy_cyc, hold_bad);
        chk("t2_busy_cyc", 32'(busy_cyc), 32'd4);
        chk("t2_d", {16'd0, d16}, 32'h00000FFF);
        chk("t2_bo", {31'd0, bo16}, 32'd0);
        chk("t2_ovf", {31'd0, ovf16}, 32'd0);
        chk("t2_hold_run", 32'(hold_bad), 32'd0);
        tick();

        // 3: signed overflow
        run16(16'h8000, 16'h0001, 1'b0, 16'h0FFF, lat, busy_cyc, hold_bad);
        chk("t3_d", {16'd0, d16}, 32'h00007FFF);
        chk("t3_bo", {31'd0, bo16}, 32'd0);
        chk("t3_ovf", {31'd0, ovf16}, 32'd1);
        tick();

        // 4: second start while busy is ignored; operand changes have no effect
        a16 = 16'h0005; b16 = 16'h0003; bi16 = 1'b0; start16 = 1'b1;
        tick();
        a16 = 16'hFFFF; b16 = 16'h0001; bi16 = 1'b1;
        tick();
        start16 = 1'b0;
        lat = 1;
        while (!done16 && lat < 20) begin
            tick();
            lat++;
        end
        chk("t4_lat", 32'(lat), 32'd4);
        chk("t4_d", {16'd0, d16}, 32'h00000002);
        chk("t4_bo", {31'd0, bo16}, 32'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done16) dones++;
        end
        chk("t4_extra_done", 32'(dones), 32'd0);

        // 5: reset during the second RUN cycle
        a16 = 16'h0123; b16 = 16'h0001; bi16 = 1'b0; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", {31'd0, busy16}, 32'd0);
        chk("t5_done", {31'd0, done16}, 32'd0);
        chk("t5_d", {16'd0, d16}, 32'h0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done16 || busy16) dones++;
        end
        chk("t5_no_done", 32'(dones), 32'd0);
        run16(16'h0010, 16'h0001, 1'b0, 16'h0000, lat, busy_cyc, hold_bad);
        chk("t5_lat", 32'(lat), 32'd4);
        chk("t5_d_new", {16'd0, d16}, 32'h0000000F);

        // 6: back-to-back, second start issued in the done cycle
        tick();
        run16(16'h0003, 16'h0005, 1'b0, 16'h000F, lat, busy_cyc, hold_bad);
        chk("t6a_d", {16'd0, d16}, 32'h0000FFFE);
        chk("t6a_bo", {31'd0, bo16}, 32'd1);
        run16(16'h7FFF, 16'hFFFF, 1'b0, 16'hFFFE, lat, busy_cyc, hold_bad);
        chk("t6b_lat", 32'(lat), 32'd4);
        chk("t6b_d", {16'd0, d16}, 32'h00008000);
        chk("t6b_bo", {31'd0, bo16}, 32'd1);
        chk("t6b_ovf", {31'd0, ovf16}, 32'd1);

        // 6 degenerate: DIGIT = WIDTH = 4
        chk("w4_rst_d", {28'd0, d4}, 32'h0);
        a4 = 4'h3; b4 = 4'h5; bi4 = 1'b1; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("w4_busy", {31'd0, busy4}, 32'd1);
        lat = 0;
        while (!done4 && lat < 10) begin
            tick();
            lat++;
        end
        chk("w4_lat", 32'(lat), 32'd1);
        chk("w4_d", {28'd0, d4}, 32'h0000000D);
        chk("w4_bo", {31'd0, bo4}, 32'd1);
        chk("w4_ovf", {31'd0, ovf4}, 32'd0);
        tick();
        chk("w4_done_pulse", {31'd0, done4}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
